llr_init_stream: RTL

Streaming, parametrised successor to the combinational per-bit LLR initialisation stage of the LDPC reconciliation decoder. It accepts the noisy sifted key LANES bits per beat over a valid/ready handshake and latches a per-block QBER index on the first beat. Each beat it emits one Q5.10 magnitude plus sign per lane, optionally right-shifted, and marks the final beat of each N_BITS-bit block. It sits between the sifted-key buffer and the variable-node memory loader.

---
 rtl/llr_init_stream_if.sv | 33 +++
 rtl/llr_init_stream.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/llr_init_stream_if.sv
// Beat-level handshake bundle between the sifted-key buffer, the LLR
// initialisation stage and the variable-node memory loader.
interface llr_init_stream_if #(
    parameter int N_BITS = 100,
    parameter int LANES  = 10,
    parameter int LLR_W  = 15
);
    localparam int BEATS  = (N_BITS + LANES - 1) / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                     in_valid;
    logic                     in_ready;
    logic                     in_first;
    logic [LANES-1:0]         in_bits;
    logic [3:0]               qber;
    logic [1:0]               scale;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*LLR_W-1:0]   out_llr;
    logic [LANES-1:0]         out_sign;
    logic                     out_last;
    logic [BEAT_W-1:0]        out_beat;

    modport master (
        output in_valid, in_first, in_bits, qber, scale, out_ready,
        input  in_ready, out_valid, out_llr, out_sign, out_last, out_beat
    );

    modport slave (
        input  in_valid, in_first, in_bits, qber, scale, out_ready,
        output in_ready, out_valid, out_llr, out_sign, out_last, out_beat
    );
endinterface

// File: rtl/llr_init_stream.sv
// Streaming LLR initialisation: turns noisy key bits into Q5.10 magnitude/sign
// pairs, LANES per beat, with a single skid-free output register stage.
module llr_init_stream #(
    parameter int N_BITS = 100,
    parameter int LANES  = 10,
    parameter int LLR_W  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    llr_init_stream_if.slave    bus,
    output logic [15:0]         block_cnt,
    output logic                seq_err
);
    localparam int BEATS  = (N_BITS + LANES - 1) / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [3:0]              qber_q, qber_d;
    logic [1:0]              scale_q, scale_d;
    logic                    out_valid_q, out_valid_d;
    logic [LANES*LLR_W-1:0]  out_llr_q, out_llr_d;
    logic [LANES-1:0]        out_sign_q, out_sign_d;
    logic                    out_last_q, out_last_d;
    logic [BEAT_W-1:0]       out_beat_q, out_beat_d;
    logic [15:0]             block_cnt_q, block_cnt_d;
    logic                    seq_err_q, seq_err_d;

    logic                    accept;
    logic                    emit;
    logic [BEAT_W-1:0]       cur_beat;
    logic [3:0]              cur_qber;
    logic [1:0]              cur_scale;
    logic [LLR_W-1:0]        cur_mag;

    // round(ln((1-p)/p) * 1024) with p = (k+1)/100
    function automatic logic [12:0] llr_rom(input logic [3:0] k);
        case (k)
            4'd0:    llr_rom = 13'd4705;
            4'd1:    llr_rom = 13'd3985;
            4'd2:    llr_rom = 13'd3560;
            4'd3:    llr_rom = 13'd3254;
            4'd4:    llr_rom = 13'd3015;
            4'd5:    llr_rom = 13'd2818;
            4'd6:    llr_rom = 13'd2649;
            4'd7:    llr_rom = 13'd2501;
            4'd8:    llr_rom = 13'd2369;
            4'd9:    llr_rom = 13'd2250;
            4'd10:   llr_rom = 13'd2141;
            4'd11:   llr_rom = 13'd2040;
            4'd12:   llr_rom = 13'd1947;
            4'd13:   llr_rom = 13'd1859;
            4'd14:   llr_rom = 13'd1776;
            default: llr_rom = 13'd1698;
        endcase
    endfunction

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        qber_d      = qber_q;
        scale_d     = scale_q;
        out_valid_d = out_valid_q;
        out_llr_d   = out_llr_q;
        out_sign_d  = out_sign_q;
        out_last_d  = out_last_q;
        out_beat_d  = out_beat_q;
        block_cnt_d = block_cnt_q;
        seq_err_d   = seq_err_q;
        emit        = 1'b0;
        cur_beat    = beat_q;
        cur_qber    = qber_q;
        cur_scale   = scale_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // A first beat always restarts framing, even if it abandons a block
        if (accept) begin
            if (bus.in_first) begin
                if (state_q == STREAM) begin
                    seq_err_d = 1'b1;
                end
                qber_d    = bus.qber;
                scale_d   = bus.scale;
                cur_qber  = bus.qber;
                cur_scale = bus.scale;
                cur_beat  = '0;
                emit      = 1'b1;
            end else if (state_q == IDLE) begin
                seq_err_d = 1'b1;
            end else begin
                emit = 1'b1;
            end
        end

        cur_mag = LLR_W'(llr_rom(cur_qber)) >> cur_scale;

        if (emit) begin
            out_valid_d = 1'b1;
            out_beat_d  = cur_beat;
            out_last_d  = (cur_beat == LAST_BEAT);
            // Lanes past the end of the block carry zero padding
            for (int i = 0; i < LANES; i++) begin
                if (32'(cur_beat) * LANES + i < N_BITS) begin
                    out_llr_d[i*LLR_W +: LLR_W] = cur_mag;
                    out_sign_d[i]               = bus.in_bits[i];
                end else begin
                    out_llr_d[i*LLR_W +: LLR_W] = '0;
                    out_sign_d[i]               = 1'b0;
                end
            end
            if (cur_beat == LAST_BEAT) begin
                state_d     = IDLE;
                beat_d      = '0;
                block_cnt_d = block_cnt_q + 16'd1;
            end else begin
                state_d = STREAM;
                beat_d  = cur_beat + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            qber_q      <= '0;
            scale_q     <= '0;
            out_valid_q <= 1'b0;
            out_llr_q   <= '0;
            out_sign_q  <= '0;
            out_last_q  <= 1'b0;
            out_beat_q  <= '0;
            block_cnt_q <= '0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            qber_q      <= qber_d;
            scale_q     <= scale_d;
            out_valid_q <= out_valid_d;
            out_llr_q   <= out_llr_d;
            out_sign_q  <= out_sign_d;
            out_last_q  <= out_last_d;
            out_beat_q  <= out_beat_d;
            block_cnt_q <= block_cnt_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_llr   = out_llr_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_beat  = out_beat_q;
    assign block_cnt     = block_cnt_q;
    assign seq_err       = seq_err_q;
endmodule
